// File: rtl/fsm_run_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fsm_run_arbiter
// Brief   : Round-robin sequencer that shares one run/done engine between
//           NUM_REQ requesters, with a per-job watchdog and ack/err pulses.
// Rev     : 1.0 - initial release
// ============================================================================
module fsm_run_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [NUM_REQ-1:0] o_err,
  output logic               o_eng_run,
  input  logic               i_eng_done,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_job_cnt
);

  localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_wd_w  = $clog2(TIMEOUT_CYC);
  localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'(TIMEOUT_CYC - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]   r_err, w_err_nxt;
  logic                 r_run, w_run_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [c_ptr_w-1:0]   r_ptr, w_ptr_nxt;
  logic [c_wd_w-1:0]    r_wdog, w_wdog_nxt;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [2*NUM_REQ-1:0] w_oh_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [NUM_REQ-1:0]   w_oh_rot;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic                 w_seen;
  logic [c_ptr_w-1:0]   w_owner;
  logic [c_ptr_w-1:0]   w_ptr_adv;

  // Rotate requests so the pointer position sits at bit 0, pick the lowest
  // set bit, then rotate the one-hot pick back to absolute positions.
  assign w_req_dbl = {i_req, i_req} >> r_ptr;
  assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

  always_comb begin
    w_oh_rot = '0;
    w_seen   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_req_rot[i] && !w_seen) begin
        w_oh_rot[i] = 1'b1;
        w_seen      = 1'b1;
      end
    end
  end

  assign w_oh_dbl  = {{NUM_REQ{1'b0}}, w_oh_rot} << r_ptr;
  assign w_pick_oh = w_oh_dbl[NUM_REQ-1:0] | w_oh_dbl[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_owner = c_ptr_w'(i);
    end
  end

  assign w_ptr_adv = (w_owner == c_ptr_last) ? '0 : w_owner + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_run_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_nxt = S_RUN;
          w_grant_nxt = w_pick_oh;
          w_run_nxt   = 1'b1;
        end
      end
      S_RUN: begin
        w_state_nxt = S_WAIT;
        w_wdog_nxt  = '0;
      end
      S_WAIT: begin
        w_wdog_nxt = r_wdog + 1'b1;
        // A done arriving on the last watchdog cycle still counts as success.
        if (i_eng_done) begin
          w_state_nxt = S_DONE;
          w_ack_nxt   = r_grant;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_ptr_nxt   = w_ptr_adv;
        end else if (r_wdog == c_wd_last) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = r_grant;
          w_ptr_nxt   = w_ptr_adv;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_run   <= w_run_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_eng_run = r_run;
  assign o_busy    = r_busy;
  assign o_job_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fsm_run_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsm_run_arbiter
// Brief   : Directed self-checking bench for fsm_run_arbiter (4 requesters,
//           16-cycle watchdog, plus a 2-bit counter instance for wrap).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_fsm_run_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  i_req;
  logic        i_eng_done;
  logic [3:0]  o_grant, o_ack, o_err;
  logic        o_eng_run, o_busy;
  logic [15:0] o_job_cnt;
  logic [3:0]  w_grant_n, w_ack_n, w_err_n;
  logic        w_run_n, w_busy_n;
  logic [1:0]  w_cnt_n;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  fsm_run_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .i_req(i_req), .o_grant(o_grant), .o_ack(o_ack),
    .o_err(o_err), .o_eng_run(o_eng_run), .i_eng_done(i_eng_done),
    .o_busy(o_busy), .o_job_cnt(o_job_cnt)
  );

  fsm_run_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16), .CNT_W(2)) u_dut_narrow (
    .clk(clk), .reset(reset), .i_req(i_req), .o_grant(w_grant_n), .o_ack(w_ack_n),
    .o_err(w_err_n), .o_eng_run(w_run_n), .i_eng_done(i_eng_done),
    .o_busy(w_busy_n), .o_job_cnt(w_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got no end want end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; i_req = '0; i_eng_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  // Engine/requester model: waits for the run pulse, answers with done d cycles
  // after it (d=0: never), drops the request on ack/err. lat = run->ack/err cycles.
  task automatic run_job(input int d, output logic [3:0] g, output logic [3:0] a,
                         output logic [3:0] e, output int runs, output int lat);
    g = '0; a = '0; e = '0; runs = 0; lat = 0;
    for (int i = 0; i < 8 && runs == 0; i++) begin
      tick();
      if (o_eng_run) runs = 1;
    end
    if (runs == 0) return;
    g = o_grant;
    for (int k = 1; k <= 40; k++) begin
      tick();
      i_eng_done = 1'b0;
      if (o_eng_run) runs++;
      if ((o_ack | o_err) != 4'b0000) begin
        a = o_ack; e = o_err; lat = k;
        i_req = i_req & ~(o_ack | o_err);
        break;
      end
      if (k == d) i_eng_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (o_grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    n_vec++; if ((o_ack | o_err) !== 4'b0000) begin n_bad++; $display("FAIL reset_ack_err: got %b/%b want 0000/0000", o_ack, o_err); end
    n_vec++; if ({o_eng_run, o_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_run_busy: got %b want 00", {o_eng_run, o_busy}); end
    n_vec++; if (o_job_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", o_job_cnt); end
    tick();
    n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_single();
    logic [3:0] g, a, e; int runs, lat;
    i_req = 4'b0001;
    run_job(5, g, a, e, runs, lat);
    exp_cnt++;
    n_vec++; if (g !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", g); end
    n_vec++; if (runs !== 1) begin n_bad++; $display("FAIL single_runs: got %0d want 1", runs); end
    n_vec++; if (a !== 4'b0001 || e !== 4'b0000) begin n_bad++; $display("FAIL single_ack: got ack %b err %b want 0001/0000", a, e); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL single_latency: got %0d want 6", lat); end
    n_vec++; if (o_job_cnt !== exp_cnt[15:0]) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", o_job_cnt, exp_cnt); end
    n_vec++; if (o_grant !== 4'b0001 || o_busy !== 1'b1) begin n_bad++; $display("FAIL single_done_state: got grant %b busy %b want 0001/1", o_grant, o_busy); end
    tick();
    n_vec++; if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_ack !== 4'b0000) begin n_bad++; $display("FAIL single_idle: got grant %b busy %b ack %b want 0000/0/0000", o_grant, o_busy, o_ack); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] g, a, e; int runs, lat;
    logic [23:0] order;
    order = 24'h818421;
    apply_reset();
    i_req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      if (j == 4) i_req = 4'b1001;
      run_job(3, g, a, e, runs, lat);
      exp_cnt++;
      n_vec++; if (g !== order[j*4 +: 4]) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", j, g, order[j*4 +: 4]); end
      n_vec++; if (a !== order[j*4 +: 4] || e !== 4'b0000) begin n_bad++; $display("FAIL rr_ack_%0d: got ack %b err %b want %b/0000", j, a, e, order[j*4 +: 4]); end
      n_vec++; if (runs !== 1 || lat !== 4) begin n_bad++; $display("FAIL rr_timing_%0d: got runs %0d lat %0d want 1/4", j, runs, lat); end
    end
    n_vec++; if (o_job_cnt !== 16'd6) begin n_bad++; $display("FAIL rr_cnt: got %0d want 6", o_job_cnt); end
    n_vec++; if (w_cnt_n !== 2'd2) begin n_bad++; $display("FAIL rr_cnt_wrap: got %0d want 2", w_cnt_n); end
  endtask

  task automatic test_timeout();
    logic [3:0] g, a, e; int runs, lat;
    logic [15:0] order;
    order = 16'h2184;
    i_req = 4'b0010;
    run_job(0, g, a, e, runs, lat);
    n_vec++; if (g !== 4'b0010) begin n_bad++; $display("FAIL to_grant: got %b want 0010", g); end
    n_vec++; if (e !== 4'b0010 || a !== 4'b0000) begin n_bad++; $display("FAIL to_err: got err %b ack %b want 0010/0000", e, a); end
    n_vec++; if (lat !== 17) begin n_bad++; $display("FAIL to_latency: got %0d want 17", lat); end
    n_vec++; if (o_job_cnt !== exp_cnt[15:0]) begin n_bad++; $display("FAIL to_cnt: got %0d want %0d", o_job_cnt, exp_cnt); end
    i_req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      run_job(2, g, a, e, runs, lat);
      exp_cnt++;
      n_vec++; if (g !== order[j*4 +: 4] || a !== g) begin n_bad++; $display("FAIL to_next_%0d: got grant %b ack %b want %b", j, g, a, order[j*4 +: 4]); end
    end
    n_vec++; if (o_job_cnt !== exp_cnt[15:0] || w_cnt_n !== exp_cnt[1:0]) begin n_bad++; $display("FAIL to_after_cnt: got %0d/%0d want %0d", o_job_cnt, w_cnt_n, exp_cnt); end
  endtask

  task automatic test_done_boundary();
    logic [3:0] g, a, e; int runs, lat;
    i_req = 4'b0001;
    run_job(16, g, a, e, runs, lat);
    exp_cnt++;
    n_vec++; if (a !== 4'b0001 || e !== 4'b0000) begin n_bad++; $display("FAIL bnd_ack: got ack %b err %b want 0001/0000", a, e); end
    n_vec++; if (lat !== 17) begin n_bad++; $display("FAIL bnd_latency: got %0d want 17", lat); end
    n_vec++; if (o_job_cnt !== exp_cnt[15:0]) begin n_bad++; $display("FAIL bnd_cnt: got %0d want %0d", o_job_cnt, exp_cnt); end
    tick();
    n_vec++; if (o_busy !== 1'b0 || o_grant !== 4'b0000 || o_err !== 4'b0000) begin n_bad++; $display("FAIL bnd_idle: got busy %b grant %b err %b want 0/0000/0000", o_busy, o_grant, o_err); end
  endtask

  task automatic test_spurious_done();
    i_eng_done = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_vec++; if ((o_ack | o_err) !== 4'b0000 || o_busy !== 1'b0 || o_job_cnt !== exp_cnt[15:0]) begin n_bad++; $display("FAIL idle_done_%0d: got ack %b err %b busy %b cnt %0d want 0000/0000/0/%0d", j, o_ack, o_err, o_busy, o_job_cnt, exp_cnt); end
    end
    i_eng_done = 1'b0;
    i_req = 4'b0010;
    tick();
    n_vec++; if (o_eng_run !== 1'b1 || o_grant !== 4'b0010) begin n_bad++; $display("FAIL run_state: got run %b grant %b want 1/0010", o_eng_run, o_grant); end
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    n_vec++; if ((o_ack | o_err) !== 4'b0000 || o_busy !== 1'b1) begin n_bad++; $display("FAIL run_done_ignored: got ack %b err %b busy %b want 0000/0000/1", o_ack, o_err, o_busy); end
    tick();
    n_vec++; if (o_ack !== 4'b0000) begin n_bad++; $display("FAIL run_done_late_ack: got %b want 0000", o_ack); end
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    exp_cnt++;
    n_vec++; if (o_ack !== 4'b0010 || o_job_cnt !== exp_cnt[15:0]) begin n_bad++; $display("FAIL run_done_real: got ack %b cnt %0d want 0010/%0d", o_ack, o_job_cnt, exp_cnt); end
    i_req = 4'b0000;
    tick();
    n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL run_done_idle: got busy %b want 0", o_busy); end
  endtask

  task automatic test_reset_mid_job();
    i_req = 4'b0001;
    tick();
    n_vec++; if (o_eng_run !== 1'b1) begin n_bad++; $display("FAIL mid_run: got %b want 1", o_eng_run); end
    tick(); tick();
    reset = 1'b1; i_req = 4'b0000;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    n_vec++; if ({o_grant, o_ack, o_err, o_eng_run, o_busy} !== 14'b0) begin n_bad++; $display("FAIL mid_reset_outs: got grant %b ack %b err %b run %b busy %b want all 0", o_grant, o_ack, o_err, o_eng_run, o_busy); end
    n_vec++; if (o_job_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset_cnt: got %0d want 0", o_job_cnt); end
    tick();
    i_eng_done = 1'b1;
    tick();
    i_eng_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_vec++; if ((o_ack | o_err) !== 4'b0000 || o_busy !== 1'b0 || o_job_cnt !== 16'd0) begin n_bad++; $display("FAIL late_done_%0d: got ack %b err %b busy %b cnt %0d want 0000/0000/0/0", j, o_ack, o_err, o_busy, o_job_cnt); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; i_req = '0; i_eng_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_boundary();
    test_spurious_done();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
